// File: rtl/stateless_cfg_loader.sv
// Two-word config frame loader for one stateless ALU atom; shadows header+constant and commits them atomically on grant.
// Optional header even-parity check under `STATELESS_CFG_PARITY_EN`; latency: commit on the first granted edge after the constant word.
module stateless_cfg_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_ready,
  input  logic                  i_commit_ok,
  output logic [3:0]            o_opcode,
  output logic [1:0]            o_sel_1,
  output logic [1:0]            o_sel_2,
  output logic [1:0]            o_sel_3,
  output logic [1:0]            o_sel_4,
  output logic [1:0]            o_sel_5,
  output logic [DATA_WIDTH-1:0] o_cons_1,
  output logic                  o_cfg_loaded,
  output logic                  o_cfg_err,
  output logic [CNT_WIDTH-1:0]  o_commit_cnt
);

  typedef enum logic [1:0] {S_HDR, S_CONS, S_COMMIT} state_t;

  state_t                  state_q;
  logic [13:0]             shd_hdr_q;
  logic [DATA_WIDTH-1:0]   shd_cons_q;
  logic                    bad_q;
  logic [3:0]              opcode_q;
  logic [1:0]              sel_1_q, sel_2_q, sel_3_q, sel_4_q, sel_5_q;
  logic [DATA_WIDTH-1:0]   cons_q;
  logic                    loaded_q;
  logic                    err_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    parity_fail;
  logic                    bad_d;

`ifdef STATELESS_CFG_PARITY_EN
  assign parity_fail = ^cfg_data[31:0];
`else
  assign parity_fail = 1'b0;
`endif

  assign bad_d     = (cfg_data[3:0] > 4'd11) | parity_fail;
  assign cfg_ready = (state_q != S_COMMIT);

  // Active outputs are only ever written in S_COMMIT, so the atom never sees a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      shd_hdr_q  <= '0;
      shd_cons_q <= '0;
      bad_q      <= 1'b0;
      opcode_q   <= '0;
      sel_1_q    <= '0;
      sel_2_q    <= '0;
      sel_3_q    <= '0;
      sel_4_q    <= '0;
      sel_5_q    <= '0;
      cons_q     <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (cfg_valid) begin
            shd_hdr_q <= cfg_data[13:0];
            bad_q     <= bad_d;
            state_q   <= S_CONS;
          end
        end
        S_CONS: begin
          // The constant is consumed even for a bad frame so framing stays aligned.
          if (cfg_valid) begin
            shd_cons_q <= cfg_data;
            if (bad_q) begin
              err_q   <= 1'b1;
              state_q <= S_HDR;
            end else begin
              state_q <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          if (i_commit_ok) begin
            opcode_q <= shd_hdr_q[3:0];
            sel_1_q  <= shd_hdr_q[5:4];
            sel_2_q  <= shd_hdr_q[7:6];
            sel_3_q  <= shd_hdr_q[9:8];
            sel_4_q  <= shd_hdr_q[11:10];
            sel_5_q  <= shd_hdr_q[13:12];
            cons_q   <= shd_cons_q;
            loaded_q <= 1'b1;
            cnt_q    <= cnt_q + 1'b1;
            state_q  <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign o_opcode     = opcode_q;
  assign o_sel_1      = sel_1_q;
  assign o_sel_2      = sel_2_q;
  assign o_sel_3      = sel_3_q;
  assign o_sel_4      = sel_4_q;
  assign o_sel_5      = sel_5_q;
  assign o_cons_1     = cons_q;
  assign o_cfg_loaded = loaded_q;
  assign o_cfg_err    = err_q;
  assign o_commit_cnt = cnt_q;

endmodule

// File: tb/tb_stateless_cfg_loader.sv
// Bench for stateless_cfg_loader: table of frames, scoreboard monitor, reset and counter-wrap sequences.
module tb_stateless_cfg_loader;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef STATELESS_CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic          i_commit_ok = 1'b0;
  logic [3:0]    o_opcode;
  logic [1:0]    o_sel_1, o_sel_2, o_sel_3, o_sel_4, o_sel_5;
  logic [DW-1:0] o_cons_1;
  logic          o_cfg_loaded, o_cfg_err;
  logic [CW-1:0] o_commit_cnt;

  stateless_cfg_loader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .i_commit_ok(i_commit_ok), .o_opcode(o_opcode),
    .o_sel_1(o_sel_1), .o_sel_2(o_sel_2), .o_sel_3(o_sel_3), .o_sel_4(o_sel_4),
    .o_sel_5(o_sel_5), .o_cons_1(o_cons_1), .o_cfg_loaded(o_cfg_loaded),
    .o_cfg_err(o_cfg_err), .o_commit_cnt(o_commit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic          bad;
    logic [3:0]    op;
    logic [1:0]    s1, s2, s3, s4, s5;
    logic [DW-1:0] cons;
  } exp_t;

  typedef struct {
    logic [DW-1:0] hdr;
    logic [DW-1:0] cons;
    int            hold;
    logic          badop;
    logic [3:0]    op;
    logic [1:0]    s1, s2, s3, s4, s5;
  } vec_t;

  exp_t          sb[$];
  exp_t          cur;
  exp_t          me;
  logic [CW-1:0] mon_cnt;
  logic          mon_loaded;
  logic [CW-1:0] drv_cnt;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every error pulse or counter step pops one expected frame; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt    = '0;
      mon_loaded = 1'b0;
      cur        = '{1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, '0};
      sb.delete();
    end else begin
      if (o_cfg_err) begin
        chk("err_not_on_commit", 32'(o_commit_cnt), 32'(mon_cnt));
        if (sb.size() == 0) begin
          chk("unexpected_err", 32'(o_cfg_err), 32'd0);
        end else begin
          me = sb.pop_front();
          chk("err_expected", 32'(me.bad), 32'd1);
        end
      end else if (o_commit_cnt != mon_cnt) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 32'(o_commit_cnt), 32'(mon_cnt));
          mon_cnt = o_commit_cnt;
        end else begin
          me = sb.pop_front();
          chk("commit_expected", 32'(me.bad), 32'd0);
          cur        = me;
          mon_cnt    = mon_cnt + 1'b1;
          mon_loaded = 1'b1;
          chk("commit_cnt", 32'(o_commit_cnt), 32'(mon_cnt));
        end
      end
      chk("opcode", 32'(o_opcode), 32'(cur.op));
      chk("sel_1", 32'(o_sel_1), 32'(cur.s1));
      chk("sel_2", 32'(o_sel_2), 32'(cur.s2));
      chk("sel_3", 32'(o_sel_3), 32'(cur.s3));
      chk("sel_4", 32'(o_sel_4), 32'(cur.s4));
      chk("sel_5", 32'(o_sel_5), 32'(cur.s5));
      chk("cons_1", o_cons_1, cur.cons);
      chk("cfg_loaded", 32'(o_cfg_loaded), 32'(mon_loaded));
    end
  end

  // Present a word and return on the negedge after the handshake edge.
  task automatic put(input logic [DW-1:0] w);
    int g;
    g = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cfg_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 32'(cfg_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic frame(input logic [DW-1:0] h, input logic [DW-1:0] c, input int hold, input exp_t e);
    sb.push_back(e);
    i_commit_ok = (hold == 0);
    put(h);
    put(c);
    cfg_valid = 1'b0;
    if (e.bad) begin
      chk("err_pulse", 32'(o_cfg_err), 32'd1);
      chk("err_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk);
      chk("err_one_cycle", 32'(o_cfg_err), 32'd0);
      chk("err_cnt_same", 32'(o_commit_cnt), 32'(drv_cnt));
    end else begin
      chk("ready_low_after_cons", 32'(cfg_ready), 32'd0);
      chk("no_commit_on_cons", 32'(o_commit_cnt), 32'(drv_cnt));
      for (int i = 0; i < hold; i++) begin
        chk("hold_ready", 32'(cfg_ready), 32'd0);
        chk("hold_cnt", 32'(o_commit_cnt), 32'(drv_cnt));
        @(negedge clk);
      end
      i_commit_ok = 1'b1;
      @(negedge clk);
      drv_cnt = drv_cnt + 1'b1;
      chk("commit_latency", 32'(o_commit_cnt), 32'(drv_cnt));
      chk("ready_after_commit", 32'(cfg_ready), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drv_cnt = '0;
  endtask

  vec_t tbl[8];

  initial begin
    exp_t e;
    logic [DW-1:0] h;
    int t0;

    tbl[0] = '{32'h0000_1A4B, 32'h0000_0007, 0, 1'b0, 4'd11, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
    tbl[1] = '{32'h0000_2D21, 32'hDEAD_BEEF, 0, 1'b0, 4'd1,  2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
    tbl[2] = '{32'h0000_1A4B, 32'h0000_0007, 5, 1'b0, 4'd11, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
    tbl[3] = '{32'h0000_000C, 32'h0000_1234, 0, 1'b1, 4'd12, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[4] = '{32'h0000_3FF0, 32'hFFFF_FFFF, 0, 1'b0, 4'd0,  2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    tbl[5] = '{32'h0000_000F, 32'h0000_0055, 2, 1'b1, 4'd15, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[6] = '{32'h0000_0001, 32'h0000_0055, 0, 1'b0, 4'd1,  2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[7] = '{32'h8000_0001, 32'h0000_00AA, 1, 1'b0, 4'd1,  2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

    drv_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cnt", 32'(o_commit_cnt), 32'd0);
    chk("rst_loaded", 32'(o_cfg_loaded), 32'd0);
    chk("rst_err", 32'(o_cfg_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      e.bad  = tbl[i].badop | (PAR & (^tbl[i].hdr));
      e.op   = tbl[i].op;
      e.s1   = tbl[i].s1;
      e.s2   = tbl[i].s2;
      e.s3   = tbl[i].s3;
      e.s4   = tbl[i].s4;
      e.s5   = tbl[i].s5;
      e.cons = tbl[i].cons;
      frame(tbl[i].hdr, tbl[i].cons, tbl[i].hold, e);
      @(negedge clk);
    end

    // Reset while a header is latched and the constant is still pending.
    i_commit_ok = 1'b1;
    put(32'h0000_2D21);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_opcode", 32'(o_opcode), 32'd0);
    chk("midrst_cons", o_cons_1, 32'd0);
    chk("midrst_sel_5", 32'(o_sel_5), 32'd0);
    chk("midrst_cnt", 32'(o_commit_cnt), 32'd0);
    chk("midrst_loaded", 32'(o_cfg_loaded), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drv_cnt = '0;
    @(negedge clk);
    e = '{1'b0, 4'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 32'h0000_0099};
    frame(32'h8000_0123, 32'h0000_0099, 0, e);
    chk("post_rst_opcode", 32'(o_opcode), 32'd3);

    // 256 back-to-back frames with cfg_valid never dropped.
    do_reset();
    @(negedge clk);
    i_commit_ok = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 256; k++) begin
      h = '0;
      h[3:0]  = 4'(k % 12);
      h[13:4] = 10'(k * 37);
      h[31]   = ^h[30:0];
      e = '{1'b0, h[3:0], h[5:4], h[7:6], h[9:8], h[11:10], h[13:12], 32'(k + 32'h100)};
      sb.push_back(e);
      put(h);
      put(32'(k + 32'h100));
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("frame_period", 32'(cyc - t0), 32'd768);
    chk("cnt_wrap", 32'(o_commit_cnt), 32'd0);
    chk("wrap_loaded", 32'(o_cfg_loaded), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
